mp_add_seq: RTL

Multi-precision add sequencer. It accepts two wide operands of `N*WORDS` bits and steps one shared `N`-bit adder slice across them, least-significant word first. Carry passes between cycles through a carry register. It sits between an operand producer and a result consumer, using valid/ready handshakes on both sides, so wide additions reuse a single narrow ripple-carry datapath.

---
 rtl/mp_add_pkg.sv | 27 ++
 rtl/mp_add_seq_add_slice.sv | 44 ++++
 rtl/mp_add_seq.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mp_add_pkg.sv
// ============================================================================
// Module  : mp_add_pkg
// Purpose : Shared types and helpers for the multi-precision add sequencer.
//           - mp_state_t   : sequencer FSM state encoding
//           - mp_idx_width : width of the word index (clog2, minimum 1 bit)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mp_add_pkg;

  typedef enum logic [1:0] {
    MP_IDLE = 2'd0,
    MP_RUN  = 2'd1,
    MP_DONE = 2'd2
  } mp_state_t;

  // A single-word configuration still needs a 1-bit index register.
  function automatic int mp_idx_width(input int words);
    int w;
    w = (words > 1) ? $clog2(words) : 1;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mp_add_seq_add_slice.sv
// ============================================================================
// Module  : add_slice
// Purpose : Combinational N-bit ripple adder slice with carry-in. Also exposes
//           the carry into the slice MSB so the caller can form the signed
//           overflow flag.
// Ports   : i_a, i_b  [N-1:0] addends
//           i_cin             carry in
//           o_sum   [N-1:0]   slice sum
//           o_cout            carry out of bit N-1
//           o_c_msb           carry into bit N-1
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module add_slice
  import mp_add_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_cin,
  output logic [N-1:0] o_sum,
  output logic         o_cout,
  output logic         o_c_msb
);

  // Add the low N-1 bits in an N-bit container; the top bit of the result is
  // exactly the carry into the slice MSB.
  logic [N-1:0] w_low;
  logic         w_msb_a;
  logic         w_msb_b;

  assign w_low   = {1'b0, i_a[N-2:0]} + {1'b0, i_b[N-2:0]} + {{(N-1){1'b0}}, i_cin};
  assign w_msb_a = i_a[N-1];
  assign w_msb_b = i_b[N-1];

  assign o_c_msb = w_low[N-1];
  assign o_sum   = {w_msb_a ^ w_msb_b ^ w_low[N-1], w_low[N-2:0]};
  assign o_cout  = (w_msb_a & w_msb_b) | (w_low[N-1] & (w_msb_a ^ w_msb_b));

endmodule

`default_nettype wire

// File: rtl/mp_add_seq.sv
// ============================================================================
// Module  : mp_add_seq
// Purpose : Multi-precision add sequencer. Captures two N*WORDS-bit operands
//           and walks one shared N-bit adder slice across them, LS word first,
//           carrying between cycles through a carry register.
// Ports   : clk, rst              clock, async active-high reset
//           in_valid / in_ready   operand handshake
//           in1, in2  [W-1:0]     operands A and B
//           sub                   1 = A-B (only with MP_ADD_SUB_EN)
//           out_valid / out_ready result handshake
//           sum       [W-1:0]     result (qualify with out_valid)
//           cout                  carry out of bit W-1 (1 = no borrow on sub)
//           overflow              two's-complement overflow of the result
// Config  : `define MP_ADD_SUB_EN to add the sub port and subtract support.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mp_add_seq
  import mp_add_pkg::*;
#(
  parameter int N     = 32,
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*WORDS-1:0] in1,
  input  logic [N*WORDS-1:0] in2,
`ifdef MP_ADD_SUB_EN
  input  logic               sub,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*WORDS-1:0] sum,
  output logic               cout,
  output logic               overflow
);

  localparam int              c_W    = N * WORDS;
  localparam int              c_IW   = mp_idx_width(WORDS);
  localparam logic [c_IW-1:0] c_LAST = c_IW'(WORDS - 1);

  mp_state_t        r_state;
  logic [c_IW-1:0]  r_idx;
  logic [c_W-1:0]   r_a;
  logic [c_W-1:0]   r_b;
  logic             r_carry;
  logic [c_W-1:0]   r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic [N-1:0]     w_a_word;
  logic [N-1:0]     w_b_word;
  logic [N-1:0]     w_b_op;
  logic             w_cin_init;
  logic [N-1:0]     w_s;
  logic             w_co;
  logic             w_cm;

  // Word mux: select word r_idx of each captured operand.
  always_comb begin
    w_a_word = '0;
    w_b_word = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (r_idx == k[c_IW-1:0]) begin
        w_a_word = r_a[k*N +: N];
        w_b_word = r_b[k*N +: N];
      end
    end
  end

`ifdef MP_ADD_SUB_EN
  logic r_sub;

  // A-B = A + ~B + 1: invert B per word and seed the carry with 1.
  assign w_b_op     = w_b_word ^ {N{r_sub}};
  assign w_cin_init = sub;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sub <= 1'b0;
    end else if (r_state == MP_IDLE && in_valid) begin
      r_sub <= sub;
    end
  end
`else
  assign w_b_op     = w_b_word;
  assign w_cin_init = 1'b0;
`endif

  add_slice #(
    .N (N)
  ) u_slice (
    .i_a     (w_a_word),
    .i_b     (w_b_op),
    .i_cin   (r_carry),
    .o_sum   (w_s),
    .o_cout  (w_co),
    .o_c_msb (w_cm)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= MP_IDLE;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        MP_IDLE: begin
          if (in_valid) begin
            r_a     <= in1;
            r_b     <= in2;
            r_carry <= w_cin_init;
            r_idx   <= '0;
            r_state <= MP_RUN;
          end
        end
        MP_RUN: begin
          for (int k = 0; k < WORDS; k++) begin
            if (r_idx == k[c_IW-1:0]) begin
              r_sum[k*N +: N] <= w_s;
            end
          end
          r_carry <= w_co;
          if (r_idx == c_LAST) begin
            r_cout  <= w_co;
            // Signed overflow: carry into the top bit differs from carry out.
            r_ovf   <= w_cm ^ w_co;
            r_state <= MP_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        MP_DONE: begin
          if (out_ready) begin
            r_state <= MP_IDLE;
          end
        end
        default: begin
          r_state <= MP_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == MP_IDLE);
  assign out_valid = (r_state == MP_DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign overflow  = r_ovf;

endmodule

`default_nettype wire
